// File: rtl/jtag_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encodings, default opcodes and the
// TAP next-state function.
package jtag_pkg;

    localparam logic [3:0] TAP_EX2DR   = 4'h0;
    localparam logic [3:0] TAP_EX1DR   = 4'h1;
    localparam logic [3:0] TAP_SHDR    = 4'h2;
    localparam logic [3:0] TAP_PAUSEDR = 4'h3;
    localparam logic [3:0] TAP_SELIR   = 4'h4;
    localparam logic [3:0] TAP_UPDDR   = 4'h5;
    localparam logic [3:0] TAP_CAPDR   = 4'h6;
    localparam logic [3:0] TAP_SELDR   = 4'h7;
    localparam logic [3:0] TAP_EX2IR   = 4'h8;
    localparam logic [3:0] TAP_EX1IR   = 4'h9;
    localparam logic [3:0] TAP_SHIR    = 4'hA;
    localparam logic [3:0] TAP_PAUSEIR = 4'hB;
    localparam logic [3:0] TAP_RTI     = 4'hC;
    localparam logic [3:0] TAP_UPDIR   = 4'hD;
    localparam logic [3:0] TAP_CAPIR   = 4'hE;
    localparam logic [3:0] TAP_TLR     = 4'hF;

    typedef enum logic [3:0] {
        ST_EX2DR   = TAP_EX2DR,
        ST_EX1DR   = TAP_EX1DR,
        ST_SHDR    = TAP_SHDR,
        ST_PAUSEDR = TAP_PAUSEDR,
        ST_SELIR   = TAP_SELIR,
        ST_UPDDR   = TAP_UPDDR,
        ST_CAPDR   = TAP_CAPDR,
        ST_SELDR   = TAP_SELDR,
        ST_EX2IR   = TAP_EX2IR,
        ST_EX1IR   = TAP_EX1IR,
        ST_SHIR    = TAP_SHIR,
        ST_PAUSEIR = TAP_PAUSEIR,
        ST_RTI     = TAP_RTI,
        ST_UPDIR   = TAP_UPDIR,
        ST_CAPIR   = TAP_CAPIR,
        ST_TLR     = TAP_TLR
    } tap_state_e;

    localparam logic [3:0] DEFAULT_IR_IDCODE = 4'h1;
    localparam logic [3:0] DEFAULT_IR_USER   = 4'h2;
    localparam logic [3:0] DEFAULT_IR_BYPASS = 4'hF;

    function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
        logic [3:0] n;
        n = TAP_TLR;
        case (s)
            TAP_TLR:     n = tms ? TAP_TLR   : TAP_RTI;
            TAP_RTI:     n = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELDR:   n = tms ? TAP_SELIR : TAP_CAPDR;
            TAP_CAPDR:   n = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_SHDR:    n = tms ? TAP_EX1DR : TAP_SHDR;
            TAP_EX1DR:   n = tms ? TAP_UPDDR : TAP_PAUSEDR;
            TAP_PAUSEDR: n = tms ? TAP_EX2DR : TAP_PAUSEDR;
            TAP_EX2DR:   n = tms ? TAP_UPDDR : TAP_SHDR;
            TAP_UPDDR:   n = tms ? TAP_SELDR : TAP_RTI;
            TAP_SELIR:   n = tms ? TAP_TLR   : TAP_CAPIR;
            TAP_CAPIR:   n = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_SHIR:    n = tms ? TAP_EX1IR : TAP_SHIR;
            TAP_EX1IR:   n = tms ? TAP_UPDIR : TAP_PAUSEIR;
            TAP_PAUSEIR: n = tms ? TAP_EX2IR : TAP_PAUSEIR;
            TAP_EX2IR:   n = tms ? TAP_UPDIR : TAP_SHIR;
            TAP_UPDIR:   n = tms ? TAP_SELDR : TAP_RTI;
            default:     n = TAP_TLR;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/jtag_pin_sync.sv
// Brings the asynchronous TCK/TMS/TDI pins into the clk domain and detects
// TCK edges on the synchronized copy.
module jtag_pin_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic tck_i,
    input  logic tms_i,
    input  logic tdi_i,
    output logic tck_rise_o,
    output logic tck_fall_o,
    output logic tms_s_o,
    output logic tdi_s_o
);

    // Bit order {tdi, tms, tck} in both synchronizer stages.
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic       tck_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            tck_prev_q <= 1'b0;
        end else begin
            sync1_q    <= {tdi_i, tms_i, tck_i};
            sync2_q    <= sync1_q;
            tck_prev_q <= sync2_q[0];
        end
    end

    assign tck_rise_o = sync2_q[0] & ~tck_prev_q;
    assign tck_fall_o = ~sync2_q[0] & tck_prev_q;
    assign tms_s_o    = sync2_q[1];
    assign tdi_s_o    = sync2_q[2];

endmodule

// File: rtl/jtag_tap_responder.sv
// Oversampled JTAG TAP: 1149.1 state machine, instruction register and the
// IDCODE / BYPASS / USER data registers, all clocked by the system clock.
module jtag_tap_responder
    import jtag_pkg::*;
#(
    parameter int unsigned         IR_LEN     = 4,
    parameter logic [31:0]         IDCODE_VAL = 32'h1234_5679,
    parameter int unsigned         USER_LEN   = 32,
    parameter logic [IR_LEN-1:0]   IR_IDCODE  = IR_LEN'(DEFAULT_IR_IDCODE),
    parameter logic [IR_LEN-1:0]   IR_USER    = IR_LEN'(DEFAULT_IR_USER),
    parameter logic [IR_LEN-1:0]   IR_BYPASS  = IR_LEN'(DEFAULT_IR_BYPASS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                jtag_tck,
    input  logic                jtag_tms,
    input  logic                jtag_tdi,
    output logic                jtag_tdo,
    input  logic [USER_LEN-1:0] user_dr_in,
    output logic [USER_LEN-1:0] user_dr_out,
    output logic                user_dr_update,
    output logic [3:0]          tap_state,
    output logic                tap_in_reset
);

    localparam int unsigned       DR_LEN     = (USER_LEN > 32) ? USER_LEN : 32;
    localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(1);

    logic tck_rise;
    logic tck_fall;
    logic tms_s;
    logic tdi_s;

    jtag_pin_sync u_pin_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .tck_i      (jtag_tck),
        .tms_i      (jtag_tms),
        .tdi_i      (jtag_tdi),
        .tck_rise_o (tck_rise),
        .tck_fall_o (tck_fall),
        .tms_s_o    (tms_s),
        .tdi_s_o    (tdi_s)
    );

    logic [3:0]          state_q,    state_d;
    logic [IR_LEN-1:0]   ir_q,       ir_d;
    logic [IR_LEN-1:0]   ir_shift_q, ir_shift_d;
    logic [DR_LEN-1:0]   dr_shift_q, dr_shift_d;
    logic                bypass_q,   bypass_d;
    logic                tdo_q,      tdo_d;
    logic [USER_LEN-1:0] user_out_q, user_out_d;
    logic                upd_q,      upd_d;

    // IR_BYPASS and every unlisted opcode fall through to the bypass bit.
    logic sel_idcode;
    logic sel_user;
    assign sel_idcode = (ir_q == IR_IDCODE);
    assign sel_user   = (ir_q == IR_USER) && (IR_USER != IR_BYPASS);

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        ir_shift_d = ir_shift_q;
        dr_shift_d = dr_shift_q;
        bypass_d   = bypass_q;
        tdo_d      = tdo_q;
        user_out_d = user_out_q;
        upd_d      = 1'b0;

        if (tck_rise) begin
            // Register actions belong to the state being left on this rise.
            case (state_q)
                TAP_CAPIR: ir_shift_d = IR_CAPTURE;
                TAP_SHIR:  ir_shift_d = {tdi_s, ir_shift_q[IR_LEN-1:1]};
                TAP_UPDIR: ir_d = ir_shift_q;
                TAP_CAPDR: begin
                    if (sel_idcode)    dr_shift_d[31:0] = IDCODE_VAL;
                    else if (sel_user) dr_shift_d[USER_LEN-1:0] = user_dr_in;
                    else               bypass_d = 1'b0;
                end
                TAP_SHDR: begin
                    if (sel_idcode)    dr_shift_d[31:0] = {tdi_s, dr_shift_q[31:1]};
                    else if (sel_user) dr_shift_d[USER_LEN-1:0] = {tdi_s, dr_shift_q[USER_LEN-1:1]};
                    else               bypass_d = tdi_s;
                end
                TAP_UPDDR: begin
                    if (sel_user) begin
                        user_out_d = dr_shift_q[USER_LEN-1:0];
                        upd_d      = 1'b1;
                    end
                end
                default: ;
            endcase

            state_d = tap_next(state_q, tms_s);
            if (state_d == TAP_TLR) ir_d = IR_IDCODE;
        end

        if (tck_fall) begin
            case (state_q)
                TAP_SHIR: tdo_d = ir_shift_q[0];
                TAP_SHDR: tdo_d = (sel_idcode || sel_user) ? dr_shift_q[0] : bypass_q;
                default:  tdo_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= TAP_TLR;
            ir_q       <= IR_IDCODE;
            ir_shift_q <= '0;
            dr_shift_q <= '0;
            bypass_q   <= 1'b0;
            tdo_q      <= 1'b1;
            user_out_q <= '0;
            upd_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            ir_shift_q <= ir_shift_d;
            dr_shift_q <= dr_shift_d;
            bypass_q   <= bypass_d;
            tdo_q      <= tdo_d;
            user_out_q <= user_out_d;
            upd_q      <= upd_d;
        end
    end

    assign jtag_tdo       = tdo_q;
    assign user_dr_out    = user_out_q;
    assign user_dr_update = upd_q;
    assign tap_state      = state_q;
    assign tap_in_reset   = (state_q == TAP_TLR);

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Bench for jtag_tap_responder: bit-banged TCK at 8 clk per period, checked
// against a table-driven TAP model plus whole-scan expectations.
module tb_jtag_tap_responder;

    localparam logic [31:0] IDC = 32'h1234_5679;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        jtag_tck = 1'b0;
    logic        jtag_tms = 1'b1;
    logic        jtag_tdi = 1'b0;
    logic        jtag_tdo;
    logic [31:0] user_dr_in = '0;
    logic [31:0] user_dr_out;
    logic        user_dr_update;
    logic [3:0]  tap_state;
    logic        tap_in_reset;

    always #5 clk = ~clk;

    jtag_tap_responder #(
        .IR_LEN     (4),
        .IDCODE_VAL (IDC),
        .USER_LEN   (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .jtag_tck       (jtag_tck),
        .jtag_tms       (jtag_tms),
        .jtag_tdi       (jtag_tdi),
        .jtag_tdo       (jtag_tdo),
        .user_dr_in     (user_dr_in),
        .user_dr_out    (user_dr_out),
        .user_dr_update (user_dr_update),
        .tap_state      (tap_state),
        .tap_in_reset   (tap_in_reset)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference TAP model: states numbered in diagram order, with separate
    // transition tables and an encoding table for the debug output.
    localparam int unsigned S_TLR = 0, S_RTI = 1, S_SELDR = 2, S_CAPDR = 3, S_SHDR = 4,
                            S_EX1DR = 5, S_PAUDR = 6, S_EX2DR = 7, S_UPDDR = 8,
                            S_SELIR = 9, S_CAPIR = 10, S_SHIR = 11, S_EX1IR = 12,
                            S_PAUIR = 13, S_EX2IR = 14, S_UPDIR = 15;
    int unsigned m_nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int unsigned m_nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    int unsigned m_enc  [16] = '{15, 12, 7, 6, 2, 1, 3, 0, 5, 4, 14, 10, 9, 11, 8, 13};

    int unsigned m_st;
    logic [3:0]  m_ir, m_irs;
    logic [31:0] m_dr, m_uout;
    logic        m_byp, m_tdo;

    task automatic model_reset();
        m_st = S_TLR; m_ir = 4'h1; m_irs = '0; m_dr = '0;
        m_byp = 1'b0; m_tdo = 1'b1; m_uout = '0;
    endtask

    task automatic model_rise(input logic tms, input logic tdi, output logic pulse);
        pulse = 1'b0;
        case (m_st)
            S_CAPIR: m_irs = 4'b0001;
            S_SHIR:  m_irs = {tdi, m_irs[3:1]};
            S_UPDIR: m_ir = m_irs;
            S_CAPDR: begin
                if (m_ir == 4'h1)      m_dr = IDC;
                else if (m_ir == 4'h2) m_dr = user_dr_in;
                else                   m_byp = 1'b0;
            end
            S_SHDR: begin
                if (m_ir == 4'h1 || m_ir == 4'h2) m_dr = {tdi, m_dr[31:1]};
                else                              m_byp = tdi;
            end
            S_UPDDR: if (m_ir == 4'h2) begin m_uout = m_dr; pulse = 1'b1; end
            default: ;
        endcase
        m_st = tms ? m_nxt1[m_st] : m_nxt0[m_st];
        if (m_st == S_TLR) m_ir = 4'h1;
    endtask

    task automatic model_fall();
        if (m_st == S_SHIR)      m_tdo = m_irs[0];
        else if (m_st == S_SHDR) m_tdo = (m_ir == 4'h1 || m_ir == 4'h2) ? m_dr[0] : m_byp;
        else                     m_tdo = 1'b1;
    endtask

    // One TCK period: 4 clk low (TMS/TDI set up, TDO sampled at the end), 4 clk high.
    task automatic tck_cycle(input logic tms, input logic tdi, output logic tdo_seen);
        logic [3:0] mask;
        logic       exp_pulse;
        jtag_tms = tms;
        jtag_tdi = tdi;
        repeat (4) @(negedge clk);
        tdo_seen = jtag_tdo;
        check_val("tdo", jtag_tdo, m_tdo);
        model_rise(tms, tdi, exp_pulse);
        jtag_tck = 1'b1;
        mask = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mask[k] = user_dr_update;
        end
        check_val("upd_pulse", mask, exp_pulse ? 4'b0100 : 4'b0000);
        check_val("tap_state", tap_state, m_enc[m_st]);
        check_val("in_reset", tap_in_reset, m_st == S_TLR);
        check_val("user_out", user_dr_out, m_uout);
        jtag_tck = 1'b0;
        model_fall();
    endtask

    task automatic tck(input logic tms, input logic tdi);
        logic d;
        tck_cycle(tms, tdi, d);
    endtask

    task automatic scan_ir(input logic [3:0] v, output logic [3:0] cap);
        tck(1'b0, 1'b0); tck(1'b1, 1'b0); tck(1'b1, 1'b0);
        tck(1'b0, 1'b0); tck(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tck_cycle(i == 3, v[i], cap[i]);
        tck(1'b1, 1'b0); tck(1'b0, 1'b0);
    endtask

    task automatic scan_dr(input logic [63:0] v, input int n, output logic [63:0] cap);
        cap = '0;
        tck(1'b0, 1'b0); tck(1'b1, 1'b0); tck(1'b0, 1'b0);
        if (n == 0) tck(1'b1, 1'b0);
        else begin
            tck(1'b0, 1'b0);
            for (int i = 0; i < n; i++) tck_cycle(i == n - 1, v[i], cap[i]);
        end
        tck(1'b1, 1'b0); tck(1'b0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_tdo"}, jtag_tdo, 1'b1);
        check_val({tag, "_state"}, tap_state, 4'hF);
        check_val({tag, "_in_reset"}, tap_in_reset, 1'b1);
        check_val({tag, "_user_out"}, user_dr_out, 32'h0);
        check_val({tag, "_upd"}, user_dr_update, 1'b0);
    endtask

    logic [3:0]  cap4;
    logic [63:0] cap64, v64, exp64;
    logic [31:0] capv, exp_user;
    logic [3:0]  op;
    int          n, len;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        scan_dr('0, 32, cap64);
        check_val("idcode_read", cap64[31:0], IDC);

        scan_ir(4'hF, cap4);
        check_val("ir_capture", cap4, 4'b0001);
        scan_dr(64'h0D, 5, cap64);
        check_val("bypass_delay", cap64[4:0], 5'b11010);

        scan_ir(4'h2, cap4);
        scan_dr(64'hA5A5_1234, 32, cap64);
        check_val("user_write", user_dr_out, 32'hA5A5_1234);

        user_dr_in = 32'hDEAD_BEEF;
        scan_dr('0, 32, cap64);
        check_val("user_capture", cap64[31:0], 32'hDEAD_BEEF);
        scan_dr('0, 0, cap64);
        check_val("zero_len_update", user_dr_out, 32'hDEAD_BEEF);

        user_dr_in = '1;
        scan_dr('0, 0, cap64);
        tck(1'b0, 1'b0); tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b0, 1'b0);
        repeat (5) tck(1'b1, 1'b1);
        check_val("tms_reset", tap_in_reset, 1'b1);
        scan_dr('0, 32, cap64);
        check_val("idcode_after_tlr", cap64[31:0], IDC);
        check_val("user_hold_tlr", user_dr_out, 32'hFFFF_FFFF);

        tck(1'b0, 1'b0); tck(1'b1, 1'b0); tck(1'b0, 1'b0); tck(1'b0, 1'b0);
        repeat (10) tck(1'b0, 1'($urandom));
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_shift_rst");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        scan_dr('0, 32, cap64);
        check_val("idcode_after_rst", cap64[31:0], IDC);

        for (int it = 0; it < 30; it++) begin
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) tck(1'($urandom), 1'($urandom));
            repeat (5) tck(1'b1, 1'($urandom));
            case ($urandom_range(0, 3))
                0:       op = 4'h1;
                1:       op = 4'h2;
                2:       op = 4'hF;
                default: op = 4'($urandom);
            endcase
            scan_ir(op, cap4);
            check_val("rand_ir_capture", cap4, 4'b0001);

            user_dr_in = $urandom;
            n   = $urandom_range(0, 40);
            v64 = {$urandom, $urandom};
            if (op == 4'h1)      begin capv = IDC;        len = 32; end
            else if (op == 4'h2) begin capv = user_dr_in; len = 32; end
            else                 begin capv = '0;         len = 1;  end
            // Stream seen on TDO: captured register contents, then the TDI bits.
            exp64 = '0;
            for (int i = 0; i < n; i++) exp64[i] = (i < len) ? capv[i] : v64[i - len];
            for (int j = 0; j < 32; j++) exp_user[j] = (j + n < 32) ? capv[j + n] : v64[j + n - 32];
            scan_dr(v64, n, cap64);
            check_val("rand_dr_tdo", cap64, exp64);
            if (op == 4'h2) check_val("rand_user_out", user_dr_out, exp_user);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/jtag_tap_responder.md
Name: jtag_tap_responder

Overview:
- JTAG target-side TAP. Receives TCK/TMS/TDI from an external probe or the FTDI bit-bang bridge and returns TDO.
- All JTAG pins are oversampled in the system clock domain. No TCK clock net is used.
- Implements the 16-state IEEE 1149.1 TAP FSM, an instruction register, and three data registers: IDCODE, BYPASS and a USER register with a parallel fabric interface.

Parameters:
- IR_LEN, 4: instruction register width (≥2).
- IDCODE_VAL, 32'h1234_5679: value captured by IDCODE; bit0 must be 1.
- USER_LEN, 32: USER data register width.
- IR_IDCODE, 4'h1: IDCODE opcode.
- IR_USER, 4'h2: USER opcode.
- IR_BYPASS, 4'hF: BYPASS opcode. Any unlisted opcode also selects BYPASS.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- jtag_tck, input, 1: TCK pin, asynchronous.
- jtag_tms, input, 1: TMS pin, asynchronous.
- jtag_tdi, input, 1: TDI pin, asynchronous.
- jtag_tdo, output, 1: TDO pin.
- user_dr_in, input, USER_LEN: value captured in Capture-DR when IR=IR_USER.
- user_dr_out, output, USER_LEN: value latched in Update-DR when IR=IR_USER.
- user_dr_update, output, 1: one-clk pulse when user_dr_out is written.
- tap_state, output, 4: current TAP state encoding, for debug LEDs.
- tap_in_reset, output, 1: high while in Test-Logic-Reset.

Behaviour:
- Reset (rst_n=0, async):
  - state = Test-Logic-Reset; IR = IR_IDCODE.
  - jtag_tdo = 1; user_dr_out = 0; user_dr_update = 0; synchronizers and edge detector cleared to 0.
- Input conditioning:
  - tck/tms/tdi each pass through a 2-FF synchronizer, plus a tck_prev register.
  - rise = tck_s & ~tck_prev; fall = ~tck_s & tck_prev.
  - tms_s/tdi_s are sampled on the same clk as rise.
- Pin timing:
  - Latency from a TCK pin edge to the state/register change is 3 clk.
  - Required pin timing: TCK high and low each ≥4 clk periods; TMS/TDI setup to TCK rise ≥4 clk.
  - Faster TCK is unsupported (undefined, no lockup guarantee).
- TAP FSM, advanced only on rise, standard 1149.1 transitions on tms_s:
  - States: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR.
  - Five consecutive rises with TMS=1 reach TLR from any state.
- Actions on rise, keyed on the state being left, i.e. before the transition:
  - CapIR: ir_shift = {0…0,2'b01}.
  - ShIR: ir_shift = {tdi_s, ir_shift[IR_LEN-1:1]}.
  - UpdIR: IR = ir_shift.
  - CapDR: IDCODE → dr_shift = IDCODE_VAL; USER → dr_shift = user_dr_in; BYPASS → bypass bit = 0.
  - ShDR: shift LSB-first with TDI entering the MSB of the selected register. Bypass is a 1-bit register.
  - UpdDR with IR=IR_USER: user_dr_out = dr_shift[USER_LEN-1:0]; user_dr_update = 1 for exactly one clk. Other IRs: no effect.
  - Entering TLR: IR = IR_IDCODE. user_dr_out holds its value.
- TDO:
  - Updated only on fall.
  - In ShIR: ir_shift[0]. In ShDR: LSB of the selected DR (bypass bit for BYPASS).
  - Any other state: jtag_tdo = 1.
  - Holds between fall edges.
- Width rules:
  - dr_shift width = max(32, USER_LEN).
  - For IDCODE, only the low 32 bits shift; TDI enters bit 31.
- Boundary cases:
  - Zero-length shift (CapDR→Ex1DR→UpdDR): USER update writes the captured user_dr_in back unchanged.
  - user_dr_in is sampled only in the CapDR rise cycle.
  - rst_n asserted mid-shift: immediate return to reset values; the partial shift is discarded.

Decomposition:
- Package jtag_pkg:
  - TAP state enum (4-bit, TLR=4'hF, RTI=4'hC, …, per the 1149.1 table).
  - Default opcode constants IR_IDCODE, IR_USER, IR_BYPASS.
- One sub-module, jtag_pin_sync:
  - 3 × 2-FF synchronizer plus TCK edge detector.
  - Outputs tck_rise, tck_fall, tms_s, tdi_s.
- The FSM and registers remain in jtag_tap_responder.

Test Plan:
- IDCODE readout: rst_n pulse; TCK = 8 clk period; TMS path 0,1,0,0 to ShDR; 32 shifts with TDI=0 → TDO bits LSB-first = 32'h1234_5679. tap_state passes through CapDR and ShDR.
- IR capture and BYPASS: shift IR with TDI=4'hF → captured TDO = 4'b0001 (LSB first 1,0,0,0). Then ShDR with TDI pattern 1,0,1,1,0 → TDO = 0,1,0,1,1 (one-bit delay).
- USER write: IR=4'h2, shift 32'hA5A5_1234 → on UpdDR, user_dr_out = 32'hA5A5_1234. user_dr_update is high exactly 1 clk, 3 clk after the TCK rise.
- USER capture: user_dr_in = 32'hDEAD_BEEF, IR=USER, CapDR + 32 shifts → TDO = 32'hDEAD_BEEF LSB-first. A zero-length shift leaves user_dr_out = 32'hDEAD_BEEF.
- TMS reset: from ShDR with IR=USER, 5 rises with TMS=1 → tap_in_reset=1 and IR=IDCODE. A subsequent DR scan returns IDCODE_VAL; user_dr_out is unchanged.
- Async reset mid-shift: drop rst_n after 10 of 32 ShDR bits → in the same clk jtag_tdo=1, tap_state=TLR, user_dr_out=0, no update pulse. Release and re-scan → correct IDCODE.
